temperature_alarm_controller: RTL and testbench
===============================================

// Module: temperature_alarm_controller
// PURPOSE
//  Consumer of temperatureAbnormalityDetector flags (lowTempAbnormality/highTempAbnormality).
//  Confirms an abnormality over CONFIRM_CNT consecutive valid samples, then latches an alarm.
//  Drives heater/cooler actuators, holds them on for a minimum time, clears on operator ack.
//  Sits between the detector and the plant actuator/operator-panel logic.
// PARAMETERS
//  CONFIRM_CNT  4   consecutive valid abnormal samples needed to raise alarm (>=1)
//  HOLD_CYCLES  16  min clk cycles actuator stays on after ack before returning to idle (>=1)
//  CNT_W        8   width of internal confirm/hold counters; must hold max(CONFIRM_CNT,HOLD_CYCLES)
// PORTS
//  clk                 in   1  system clock, rising edge
//  rstN                in   1  asynchronous active-low reset
//  sampleValid         in   1  detector flags valid this cycle (one sample per high cycle)
//  lowTempAbnormality  in   1  detector low-temperature flag
//  highTempAbnormality in   1  detector high-temperature flag
//  alarmAck            in   1  operator acknowledge, level sampled each cycle
//  heaterOn            out  1  heater actuator enable
//  coolerOn            out  1  cooler actuator enable
//  alarmActive         out  1  alarm latched, awaiting ack
//  alarmType           out  2  00 none, 01 low, 10 high, 11 sensor fault
//  alarmCount          out  8  (only with ALARM_EVENT_COUNT_EN) saturating alarm-raise count
// BEHAVIOUR
//  - Reset (rstN=0, async): state IDLE, counters 0, all outputs 0. Reset mid-alarm drops alarm immediately.
//  - All outputs registered; change one cycle after the triggering clk edge.
//  - Flags ignored when sampleValid=0; counters neither advance nor clear on invalid cycles.
//  - Sample classes: LOW (low=1,high=0), HIGH (high=1,low=0), NORM (both 0), FAULT (both 1).
//  - States: IDLE, CONF_LOW, CONF_HIGH, ALARM_LOW, ALARM_HIGH, ALARM_FAULT, HOLD.
//  - IDLE: LOW -> CONF_LOW cnt=1; HIGH -> CONF_HIGH cnt=1; FAULT -> ALARM_FAULT directly.
//    CONFIRM_CNT=1: a LOW/HIGH sample goes straight to ALARM_LOW/ALARM_HIGH.
//  - CONF_x: same class -> cnt++; on cnt reaching CONFIRM_CNT -> ALARM_x.
//    NORM -> IDLE cnt=0; opposite class -> other CONF state cnt=1; FAULT -> ALARM_FAULT.
//  - ALARM_LOW: alarmActive=1, alarmType=01, heaterOn=1. ALARM_HIGH: type 10, coolerOn=1.
//    ALARM_FAULT: type 11, heaterOn=coolerOn=0.
//  - heaterOn and coolerOn never 1 in the same cycle.
//  - In ALARM_LOW/HIGH new samples are ignored (latched) except FAULT -> ALARM_FAULT.
//  - alarmAck=1 in any ALARM state -> HOLD, hold cnt=0; alarmActive=0, alarmType keeps last value.
//    Actuator stays on in HOLD. alarmAck in non-ALARM states ignored.
//  - HOLD: cnt++ every cycle; at cnt=HOLD_CYCLES-1 -> IDLE, actuators off, alarmType=00.
//    FAULT sample during HOLD -> ALARM_FAULT (fault preempts hold).
//  - Ack in same cycle as alarm-raising sample: alarm raised first; ack only acts from ALARM state next cycle.
//  - Counters saturate, never wrap.
// CONFIGURATION
//  - Macro ALARM_EVENT_COUNT_EN defined: port alarmCount present; increments by 1 on each entry
//    into any ALARM state, saturates at 255, reset to 0 by rstN only.
//  - Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  - Reset: rstN=0 mid-ALARM_HIGH -> all outputs 0 asynchronously, before next clk edge.
//  - 4 valid LOW samples (CONFIRM_CNT=4) -> heaterOn=1, alarmActive=1, alarmType=01 cycle after 4th.
//  - 3 HIGH, 1 NORM, 3 HIGH -> no alarm; 4th consecutive HIGH -> coolerOn=1, alarmType=10.
//  - LOW,LOW,sampleValid=0 x5,LOW,LOW -> alarm raised (invalid cycles neither count nor clear).
//  - low=high=1 valid once from IDLE -> alarmType=11, heaterOn=coolerOn=0, alarmActive=1.
//  - ALARM_LOW, alarmAck 1 cycle -> alarmActive=0, heaterOn stays 1 for 16 cycles, then all 0;
//    with ALARM_EVENT_COUNT_EN, 300 alarm events -> alarmCount=255.

Source files
------------

// File: rtl/temperature_alarm_controller.sv
// Confirms detector abnormality flags over consecutive valid samples, latches an alarm,
// drives heater/cooler and holds them after ack. Optional macro: ALARM_EVENT_COUNT_EN.
module temperature_alarm_controller #(
    parameter int CONFIRM_CNT = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       sampleValid,
    input  logic       lowTempAbnormality,
    input  logic       highTempAbnormality,
    input  logic       alarmAck,
    output logic       heaterOn,
    output logic       coolerOn,
    output logic       alarmActive,
`ifdef ALARM_EVENT_COUNT_EN
    output logic [1:0] alarmType,
    output logic [7:0] alarmCount
`else
    output logic [1:0] alarmType
`endif
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CONF_LOW    = 3'd1,
        CONF_HIGH   = 3'd2,
        ALARM_LOW   = 3'd3,
        ALARM_HIGH  = 3'd4,
        ALARM_FAULT = 3'd5,
        HOLD        = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt, cnt_inc;
    logic             next_heater, next_cooler, next_active;
    logic [1:0]       next_type;
    logic             is_low, is_high, is_norm, is_fault;

    assign is_low   = sampleValid &  lowTempAbnormality & ~highTempAbnormality;
    assign is_high  = sampleValid & ~lowTempAbnormality &  highTempAbnormality;
    assign is_norm  = sampleValid & ~lowTempAbnormality & ~highTempAbnormality;
    assign is_fault = sampleValid &  lowTempAbnormality &  highTempAbnormality;
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Outputs are registered from the next-state decode so they follow the triggering edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            cnt         <= '0;
            heaterOn    <= 1'b0;
            coolerOn    <= 1'b0;
            alarmActive <= 1'b0;
            alarmType   <= 2'b00;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            heaterOn    <= next_heater;
            coolerOn    <= next_cooler;
            alarmActive <= next_active;
            alarmType   <= next_type;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            IDLE: begin
                if (is_fault) begin
                    next_state = ALARM_FAULT;
                    next_cnt   = '0;
                end else if (is_low) begin
                    next_state = (CONFIRM_CNT <= 1) ? ALARM_LOW : CONF_LOW;
                    next_cnt   = (CONFIRM_CNT <= 1) ? '0 : CNT_ONE;
                end else if (is_high) begin
                    next_state = (CONFIRM_CNT <= 1) ? ALARM_HIGH : CONF_HIGH;
                    next_cnt   = (CONFIRM_CNT <= 1) ? '0 : CNT_ONE;
                end
            end
            CONF_LOW, CONF_HIGH: begin
                if (is_fault) begin
                    next_state = ALARM_FAULT;
                    next_cnt   = '0;
                end else if (is_norm) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if ((is_low && state == CONF_LOW) || (is_high && state == CONF_HIGH)) begin
                    if (cnt >= CONFIRM_LAST) begin
                        next_state = (state == CONF_LOW) ? ALARM_LOW : ALARM_HIGH;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt_inc;
                    end
                end else if (is_low || is_high) begin
                    next_state = is_low ? CONF_LOW : CONF_HIGH;
                    next_cnt   = CNT_ONE;
                end
            end
            // Ack wins over a simultaneous fault so a persistent fault can still be acknowledged.
            ALARM_LOW, ALARM_HIGH, ALARM_FAULT: begin
                if (alarmAck) begin
                    next_state = HOLD;
                    next_cnt   = '0;
                end else if (is_fault) begin
                    next_state = ALARM_FAULT;
                    next_cnt   = '0;
                end
            end
            HOLD: begin
                if (is_fault) begin
                    next_state = ALARM_FAULT;
                    next_cnt   = '0;
                end else if (cnt >= HOLD_LAST) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt_inc;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // HOLD keeps the last alarm type, so the actuator choice is taken from the current type.
    always_comb begin
        next_heater = 1'b0;
        next_cooler = 1'b0;
        next_active = 1'b0;
        next_type   = 2'b00;
        unique case (next_state)
            ALARM_LOW: begin
                next_active = 1'b1;
                next_type   = 2'b01;
                next_heater = 1'b1;
            end
            ALARM_HIGH: begin
                next_active = 1'b1;
                next_type   = 2'b10;
                next_cooler = 1'b1;
            end
            ALARM_FAULT: begin
                next_active = 1'b1;
                next_type   = 2'b11;
            end
            HOLD: begin
                next_type   = alarmType;
                next_heater = (alarmType == 2'b01);
                next_cooler = (alarmType == 2'b10);
            end
            default: begin
                next_type = 2'b00;
            end
        endcase
    end

`ifdef ALARM_EVENT_COUNT_EN
    logic alarm_entry;

    assign alarm_entry = (next_state == ALARM_LOW || next_state == ALARM_HIGH ||
                          next_state == ALARM_FAULT) && (next_state != state);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            alarmCount <= 8'd0;
        end else if (alarm_entry && alarmCount != 8'hFF) begin
            alarmCount <= alarmCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_temperature_alarm_controller.sv
// Directed and randomized checks of temperature_alarm_controller against a
// behavioural model of alarm confirmation, latching, ack and hold.
module tb_temperature_alarm_controller;

    localparam int CONFIRM = 4;
    localparam int HOLD    = 16;

    logic       clk = 1'b0;
    logic       rstN;
    logic       sampleValid, lowTempAbnormality, highTempAbnormality, alarmAck;
    logic       heaterOn, coolerOn, alarmActive;
    logic [1:0] alarmType;
`ifdef ALARM_EVENT_COUNT_EN
    logic [7:0] alarmCount;
`endif

    int checks = 0;
    int errors = 0;

    // Model: the alarm type (0 none,1 low,2 high,3 fault), whether it awaits ack,
    // cycles of actuator hold remaining, and the current run of identical samples.
    int m_type, m_active, m_hold_left, m_run_class, m_run_len, m_count;

    temperature_alarm_controller #(
        .CONFIRM_CNT(CONFIRM), .HOLD_CYCLES(HOLD), .CNT_W(8)
    ) dut (
        .clk(clk), .rstN(rstN), .sampleValid(sampleValid),
        .lowTempAbnormality(lowTempAbnormality), .highTempAbnormality(highTempAbnormality),
        .alarmAck(alarmAck), .heaterOn(heaterOn), .coolerOn(coolerOn),
        .alarmActive(alarmActive),
`ifdef ALARM_EVENT_COUNT_EN
        .alarmType(alarmType), .alarmCount(alarmCount)
`else
        .alarmType(alarmType)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".heaterOn"}, {7'd0, heaterOn},
                     8'((m_type == 1) && (m_active != 0 || m_hold_left > 0)));
        check_output({tag, ".coolerOn"}, {7'd0, coolerOn},
                     8'((m_type == 2) && (m_active != 0 || m_hold_left > 0)));
        check_output({tag, ".alarmActive"}, {7'd0, alarmActive}, 8'(m_active));
        check_output({tag, ".alarmType"}, {6'd0, alarmType}, 8'(m_type));
`ifdef ALARM_EVENT_COUNT_EN
        check_output({tag, ".alarmCount"}, alarmCount, 8'(m_count));
`endif
    endtask

    task automatic model_reset();
        m_type = 0; m_active = 0; m_hold_left = 0;
        m_run_class = 0; m_run_len = 0; m_count = 0;
    endtask

    task automatic raise(input int t);
        m_active = 1;
        m_type = t;
        m_run_len = 0;
        m_hold_left = 0;
        if (m_count < 255) m_count++;
    endtask

    task automatic model_update(input bit v, input bit l, input bit h, input bit a);
        bit fl, lo, hi, nm;
        int c;
        fl = v && l && h;
        lo = v && l && !h;
        hi = v && h && !l;
        nm = v && !l && !h;
        if (m_active != 0) begin
            if (a) begin
                m_active = 0;
                m_hold_left = HOLD;
            end else if (fl && m_type != 3) begin
                raise(3);
            end
        end else if (m_hold_left > 0) begin
            if (fl) raise(3);
            else begin
                m_hold_left--;
                if (m_hold_left == 0) m_type = 0;
            end
        end else if (fl) begin
            raise(3);
        end else if (lo || hi) begin
            c = lo ? 1 : 2;
            if (c == m_run_class) m_run_len++;
            else begin
                m_run_class = c;
                m_run_len = 1;
            end
            if (m_run_len >= CONFIRM) raise(c);
        end else if (nm) begin
            m_run_len = 0;
        end
    endtask

    task automatic apply_stimulus(input bit v, input bit l, input bit h, input bit a, input string tag);
        @(negedge clk);
        sampleValid = v; lowTempAbnormality = l; highTempAbnormality = h; alarmAck = a;
        @(posedge clk);
        model_update(v, l, h, a);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstN = 1'b0;
        sampleValid = 0; lowTempAbnormality = 0; highTempAbnormality = 0; alarmAck = 0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        bit v, l, h, a;
        int cls;
        rstN = 1'b0;
        sampleValid = 0; lowTempAbnormality = 0; highTempAbnormality = 0; alarmAck = 0;
        model_reset();
        #3;
        check_all("reset_initial");
        do_reset();

        // Four LOW samples raise a low alarm; ack then a 16-cycle heater hold.
        for (int i = 0; i < 4; i++) apply_stimulus(1, 1, 0, 0, "low_confirm");
        check_output("low_alarm_heater", {7'd0, heaterOn}, 8'd1);
        check_output("low_alarm_type", {6'd0, alarmType}, 8'd1);
        apply_stimulus(0, 0, 0, 1, "low_ack");
        for (int i = 0; i < HOLD; i++) apply_stimulus(0, 0, 0, 0, "low_hold");
        check_output("hold_done_heater", {7'd0, heaterOn}, 8'd0);

        // A NORM sample breaks a HIGH run; four consecutive HIGH then alarm.
        for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 1, 0, "high_run1");
        apply_stimulus(1, 0, 0, 0, "high_norm");
        for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 1, 0, "high_run2");
        check_output("high_not_yet", {7'd0, alarmActive}, 8'd0);
        apply_stimulus(1, 0, 1, 0, "high_run2_4th");
        check_output("high_alarm_cooler", {7'd0, coolerOn}, 8'd1);
        check_output("high_alarm_type", {6'd0, alarmType}, 8'd2);

        // Asynchronous reset mid alarm clears outputs before the next edge.
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rstN = 1'b1;

        // Invalid cycles neither count nor clear a confirmation run.
        apply_stimulus(1, 1, 0, 0, "gap_low");
        apply_stimulus(1, 1, 0, 0, "gap_low");
        for (int i = 0; i < 5; i++) apply_stimulus(0, i[0], ~i[0], 0, "gap_invalid");
        apply_stimulus(1, 1, 0, 0, "gap_low");
        apply_stimulus(1, 1, 0, 0, "gap_low_4th");
        check_output("gap_alarm_active", {7'd0, alarmActive}, 8'd1);
        apply_stimulus(0, 0, 0, 1, "gap_ack");
        for (int i = 0; i < HOLD; i++) apply_stimulus(1, 1, 0, 0, "gap_hold");

        // Single FAULT sample from IDLE; ack then hold with actuators off.
        apply_stimulus(1, 1, 1, 0, "fault");
        check_output("fault_type", {6'd0, alarmType}, 8'd3);
        apply_stimulus(0, 0, 0, 1, "fault_ack");
        for (int i = 0; i < HOLD + 2; i++) apply_stimulus(0, 0, 0, 0, "fault_hold");

        // Randomized traffic with sticky sample classes so alarms get confirmed.
        cls = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cls = $urandom_range(0, 2);
                if ($urandom_range(0, 9) == 0) cls = 3;
            end
            v = ($urandom_range(0, 99) < 85);
            l = (cls == 1 || cls == 3);
            h = (cls == 2 || cls == 3);
            a = ($urandom_range(0, 11) == 0);
            apply_stimulus(v, l, h, a, "random");
        end

`ifdef ALARM_EVENT_COUNT_EN
        // Alternate ack and fault so every pair is a fresh alarm entry; count saturates.
        do_reset();
        apply_stimulus(1, 1, 1, 0, "cnt_fault");
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sampleValid = 0; lowTempAbnormality = 0; highTempAbnormality = 0; alarmAck = 1;
            @(posedge clk);
            model_update(0, 0, 0, 1);
            @(negedge clk);
            sampleValid = 1; lowTempAbnormality = 1; highTempAbnormality = 1; alarmAck = 0;
            @(posedge clk);
            model_update(1, 1, 1, 0);
        end
        #1;
        check_all("cnt_saturate");
        check_output("cnt_255", alarmCount, 8'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
